instruction_decoder: RTL and testbench

Decodes the 8-bit instruction word returned by program memory for the current `pc` and drives the execute side of the datapath. It is the consumer end of the program-sequencer fetch interface: it produces `jmp`, `jmp_nz`, `jmp_addr` and `dont_jmp`, and the sequencer turns these into the next `pm_addr`. It also produces register-load enables, source selects and ALU controls, and it owns the zero flag and a debug instruction register.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/instr_fields.sv | 42 ++++
 rtl/instruction_decoder.sv | 141 ++++++++++++++
 tb/tb_instruction_decoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode constants, destination codes and FSM states for the
// instruction decoder and its field extractor.
package cpu_pkg;

  // Opcode prefixes, compared against the top bits of the instruction word
  localparam logic       OPC_LOAD = 1'b0;     // pm_data[7]
  localparam logic [1:0] OPC_MOV  = 2'b10;    // pm_data[7:6]
  localparam logic [2:0] OPC_ALU  = 3'b110;   // pm_data[7:5]
  localparam logic [3:0] OPC_JMP  = 4'b1110;  // pm_data[7:4]
  localparam logic [3:0] OPC_JNZ  = 4'b1111;  // pm_data[7:4]

  typedef enum logic [2:0] {
    DST_X0    = 3'd0,
    DST_X1    = 3'd1,
    DST_Y0    = 3'd2,
    DST_Y1    = 3'd3,
    DST_O_REG = 3'd4,
    DST_M     = 3'd5,
    DST_I     = 3'd6,
    DST_SPARE = 3'd7
  } dest_e;

  localparam logic [3:0] SRC_IMM = 4'd8;

  typedef enum logic {
    RST = 1'b0,
    RUN = 1'b1
  } state_e;

endpackage

// File: rtl/instr_fields.sv
// Purely combinational field extractor and classifier for the 8-bit
// instruction word. Exactly one class flag is set for any instruction.
module instr_fields
  import cpu_pkg::*;
(
  input  logic [7:0] instr,
  output logic       is_load,
  output logic       is_mov,
  output logic       is_nop,
  output logic       is_alu,
  output logic       is_jmp,
  output logic       is_jnz,
  output dest_e      dest,
  output logic [2:0] src,
  output logic [3:0] imm,
  output logic       op_x,
  output logic       op_y,
  output logic [2:0] fn
);

  logic       mov_form;
  logic [2:0] mov_dest;

  assign mov_form = (instr[7:6] == OPC_MOV);
  assign mov_dest = instr[5:3];

  assign is_load = (instr[7] == OPC_LOAD);
  // A move onto itself changes nothing, so it is classified as NOP, not MOV
  assign is_nop  = mov_form && (mov_dest == instr[2:0]);
  assign is_mov  = mov_form && !is_nop;
  assign is_alu  = (instr[7:5] == OPC_ALU);
  assign is_jmp  = (instr[7:4] == OPC_JMP);
  assign is_jnz  = (instr[7:4] == OPC_JNZ);

  assign dest = is_load ? dest_e'(instr[6:4]) : dest_e'(mov_dest);
  assign src  = instr[2:0];
  assign imm  = instr[3:0];
  assign op_x = instr[4];
  assign op_y = instr[3];
  assign fn   = instr[2:0];

endmodule

// File: rtl/instruction_decoder.sv
// Execute-side instruction decoder: field decode gated by a RST/RUN FSM,
// plus the zero flag, debug instruction register and retired counter.
//
// state | meaning
// RST   | held in or just leaving reset; all enables and jumps forced to 0
// RUN   | decode of pm_data drives the datapath
module instruction_decoder
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic [7:0]          pm_data,
  input  logic                alu_zero,
  output logic                jmp,
  output logic                jmp_nz,
  output logic [3:0]          jmp_addr,
  output logic                dont_jmp,
  output logic [NUM_REGS-1:0] reg_en,
  output logic                r_en,
  output logic [3:0]          src_sel,
  output logic                alu_x_sel,
  output logic                alu_y_sel,
  output logic [2:0]          alu_fn,
  output logic [7:0]          ir,
  output logic [CNT_W-1:0]    retired
);

  state_e           state_q;
  state_e           state_d;
  logic             run;
  logic             zero_q;
  logic [7:0]       ir_q;
  logic [CNT_W-1:0] retired_q;

  logic       is_load;
  logic       is_mov;
  logic       is_nop;
  logic       is_alu;
  logic       is_jmp;
  logic       is_jnz;
  dest_e      dest;
  logic [2:0] src;
  logic [3:0] imm;
  logic       op_x;
  logic       op_y;
  logic [2:0] fn;

  instr_fields u_fields (
    .instr   (pm_data),
    .is_load (is_load),
    .is_mov  (is_mov),
    .is_nop  (is_nop),
    .is_alu  (is_alu),
    .is_jmp  (is_jmp),
    .is_jnz  (is_jnz),
    .dest    (dest),
    .src     (src),
    .imm     (imm),
    .op_x    (op_x),
    .op_y    (op_y),
    .fn      (fn)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset also masks decode in its own cycle so a pending jump cannot
  // override the sequencer's return to address 0.
  assign run = (state_q == RUN) && !sync_reset;

  always_comb begin
    state_d   = state_q;
    reg_en    = '0;
    r_en      = 1'b0;
    src_sel   = 4'd0;
    alu_x_sel = 1'b0;
    alu_y_sel = 1'b0;
    alu_fn    = 3'd0;
    jmp       = 1'b0;
    jmp_nz    = 1'b0;
    jmp_addr  = 4'd0;

    unique case (state_q)
      RST:     state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RST;
    endcase

    if (run) begin
      if (is_load || is_mov) begin
        if (int'(dest) < NUM_REGS) begin
          reg_en[dest] = 1'b1;
        end
        src_sel = is_load ? SRC_IMM : {1'b0, src};
      end
      if (is_alu) begin
        r_en      = 1'b1;
        alu_x_sel = op_x;
        alu_y_sel = op_y;
        alu_fn    = fn;
      end
      if (is_jmp) begin
        jmp      = 1'b1;
        jmp_addr = imm;
      end
      if (is_jnz) begin
        jmp_nz   = 1'b1;
        jmp_addr = imm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      zero_q    <= 1'b0;
      ir_q      <= 8'd0;
      retired_q <= '0;
    end else if (run) begin
      ir_q <= pm_data;
      if (is_alu) begin
        zero_q <= alu_zero;
      end
      if (!is_nop) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign dont_jmp = zero_q;
  assign ir       = ir_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: constant vector table,
// hand-written multi-cycle sequences and randomized stimulus against a model.
module tb_instruction_decoder;

  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  typedef struct packed {
    logic [7:0] reg_en;
    logic [3:0] src_sel;
    logic       r_en;
    logic       ax;
    logic       ay;
    logic [2:0] fn;
    logic       jmp;
    logic       jnz;
    logic [3:0] addr;
  } dec_t;

  typedef struct packed {
    logic [7:0] pm;
    dec_t       exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             sync_reset;
  logic [7:0]       pm_data;
  logic             alu_zero;
  logic             jmp;
  logic             jmp_nz;
  logic [3:0]       jmp_addr;
  logic             dont_jmp;
  logic [7:0]       reg_en;
  logic             r_en;
  logic [3:0]       src_sel;
  logic             alu_x_sel;
  logic             alu_y_sel;
  logic [2:0]       alu_fn;
  logic [7:0]       ir;
  logic [CNT_W-1:0] retired;

  int total = 0;
  int bad   = 0;

  bit         m_run;
  bit         m_zf;
  int         m_ret;
  logic [7:0] m_ir;

  vec_t vecs[$];

  always #5 clk = ~clk;

  instruction_decoder #(.NUM_REGS(8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .pm_data    (pm_data),
    .alu_zero   (alu_zero),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .jmp_addr   (jmp_addr),
    .dont_jmp   (dont_jmp),
    .reg_en     (reg_en),
    .r_en       (r_en),
    .src_sel    (src_sel),
    .alu_x_sel  (alu_x_sel),
    .alu_y_sel  (alu_y_sel),
    .alu_fn     (alu_fn),
    .ir         (ir),
    .retired    (retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction formats, using opcode ranges
  function automatic dec_t ref_decode(input int pm, input bit active);
    dec_t d;
    int   dd;
    int   ss;
    int   v;
    d = '0;
    if (!active) return d;
    if (pm < 128) begin
      d.reg_en  = 8'(1 << (pm / 16));
      d.src_sel = 4'd8;
    end else if (pm < 192) begin
      dd = (pm - 128) / 8;
      ss = pm % 8;
      if (dd != ss) begin
        d.reg_en  = 8'(1 << dd);
        d.src_sel = 4'(ss);
      end
    end else if (pm < 224) begin
      v      = pm - 192;
      d.r_en = 1'b1;
      d.ax   = 1'(v / 16);
      d.ay   = 1'((v / 8) % 2);
      d.fn   = 3'(v % 8);
    end else if (pm < 240) begin
      d.jmp  = 1'b1;
      d.addr = 4'(pm - 224);
    end else begin
      d.jnz  = 1'b1;
      d.addr = 4'(pm - 240);
    end
    return d;
  endfunction

  function automatic bit ref_nop(input int pm);
    return (pm >= 128) && (pm < 192) && (((pm - 128) / 8) == (pm % 8));
  endfunction

  task automatic model_edge();
    if (sync_reset) begin
      m_run = 1'b0;
      m_zf  = 1'b0;
      m_ret = 0;
      m_ir  = 8'd0;
    end else begin
      if (m_run) begin
        m_ir = pm_data;
        if (!ref_nop(int'(pm_data))) m_ret = (m_ret + 1) % CNT_MOD;
        if (pm_data >= 8'd192 && pm_data < 8'd224) m_zf = alu_zero;
      end
      m_run = 1'b1;
    end
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clock();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_dec(input string tag, input dec_t e);
    chk({tag, ".reg_en"},   32'(reg_en),    32'(e.reg_en));
    chk({tag, ".src_sel"},  32'(src_sel),   32'(e.src_sel));
    chk({tag, ".r_en"},     32'(r_en),      32'(e.r_en));
    chk({tag, ".alu_x"},    32'(alu_x_sel), 32'(e.ax));
    chk({tag, ".alu_y"},    32'(alu_y_sel), 32'(e.ay));
    chk({tag, ".alu_fn"},   32'(alu_fn),    32'(e.fn));
    chk({tag, ".jmp"},      32'(jmp),       32'(e.jmp));
    chk({tag, ".jmp_nz"},   32'(jmp_nz),    32'(e.jnz));
    chk({tag, ".jmp_addr"}, 32'(jmp_addr),  32'(e.addr));
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".dont_jmp"}, 32'(dont_jmp), 32'(m_zf));
    chk({tag, ".retired"},  32'(retired),  32'(m_ret));
    chk({tag, ".ir"},       32'(ir),       32'(m_ir));
  endtask

  task automatic check_all(input string tag);
    check_dec(tag, ref_decode(int'(pm_data), m_run && !sync_reset));
    check_state(tag);
  endtask

  task automatic add_vec(input logic [7:0] pm, input logic [23:0] exp);
    vec_t v;
    v.pm  = pm;
    v.exp = dec_t'(exp);
    vecs.push_back(v);
  endtask

  initial begin
    // expected fields: reg_en, src_sel, r_en, x, y, fn, jmp, jnz, addr
    add_vec(8'h27, {8'h04, 4'd8, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'h0F, {8'h01, 4'd8, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'h7A, {8'h80, 4'd8, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'h8C, {8'h02, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'h8D, {8'h02, 4'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'hBE, {8'h80, 4'd6, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'h9B, {8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'h80, {8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'hBF, {8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'hD3, {8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 4'd0});
    add_vec(8'hDF, {8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 4'd0});
    add_vec(8'hC8, {8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0});
    add_vec(8'hE9, {8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 4'd9});
    add_vec(8'hE0, {8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 4'd0});
    add_vec(8'hF4, {8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'd4});
    add_vec(8'hFF, {8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'd15});

    sync_reset = 1'b1;
    pm_data    = 8'hE5;
    alu_zero   = 1'b0;
    m_run = 1'b0; m_zf = 1'b0; m_ret = 0; m_ir = 8'd0;
    clock();

    // Reset held with a jump on the bus: nothing may escape
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst.jmp", 32'(jmp), 32'd0);
      chk("rst.reg_en", 32'(reg_en), 32'd0);
      chk("rst.r_en", 32'(r_en), 32'd0);
      chk("rst.dont_jmp", 32'(dont_jmp), 32'd0);
      chk("rst.retired", 32'(retired), 32'd0);
      chk("rst.ir", 32'(ir), 32'd0);
      clock();
    end
    sync_reset = 1'b0;
    settle();
    chk("release.jmp_rst_state", 32'(jmp), 32'd0);
    clock();
    settle();
    chk("first_run.jmp", 32'(jmp), 32'd1);
    chk("first_run.jmp_addr", 32'(jmp_addr), 32'd5);
    clock();
    settle();
    chk("first_run.ir", 32'(ir), 32'hE5);
    chk("first_run.retired", 32'(retired), 32'd1);

    foreach (vecs[i]) begin
      pm_data  = vecs[i].pm;
      alu_zero = 1'($urandom_range(0, 1));
      settle();
      check_dec($sformatf("vec%0d_%02h", i, vecs[i].pm), vecs[i].exp);
      check_state($sformatf("vec%0d_%02h", i, vecs[i].pm));
      clock();
    end

    // NOP leaves the counter alone but still lands in ir
    pm_data = 8'h27; clock();
    pm_data = 8'h9B; clock();
    settle();
    chk("nop.ir", 32'(ir), 32'h9B);
    check_state("nop");

    // ALU result is visible to an immediately following jmp_nz
    pm_data = 8'hD3; alu_zero = 1'b1; clock();
    pm_data = 8'hF4; alu_zero = 1'b0; settle();
    chk("jnz_z1.dont_jmp", 32'(dont_jmp), 32'd1);
    chk("jnz_z1.jmp_nz", 32'(jmp_nz), 32'd1);
    chk("jnz_z1.jmp_addr", 32'(jmp_addr), 32'd4);
    clock();
    pm_data = 8'hD3; alu_zero = 1'b0; clock();
    pm_data = 8'hF4; alu_zero = 1'b1; settle();
    chk("jnz_z0.dont_jmp", 32'(dont_jmp), 32'd0);
    chk("jnz_z0.jmp_nz", 32'(jmp_nz), 32'd1);
    clock();
    settle();
    chk("jnz_z0.flag_held", 32'(dont_jmp), 32'd0);

    // Reset arriving together with a jump
    pm_data = 8'hD3; alu_zero = 1'b1; clock();
    pm_data = 8'hE9; alu_zero = 1'b0; settle();
    chk("jmp.jmp", 32'(jmp), 32'd1);
    chk("jmp.jmp_addr", 32'(jmp_addr), 32'd9);
    chk("jmp.dont_jmp", 32'(dont_jmp), 32'd1);
    sync_reset = 1'b1; settle();
    chk("jmp_rst.jmp", 32'(jmp), 32'd0);
    chk("jmp_rst.jmp_addr", 32'(jmp_addr), 32'd0);
    clock();
    sync_reset = 1'b0; pm_data = 8'h00; settle();
    chk("after_rst.dont_jmp", 32'(dont_jmp), 32'd0);
    chk("after_rst.retired", 32'(retired), 32'd0);
    chk("after_rst.ir", 32'(ir), 32'd0);
    chk("after_rst.reg_en", 32'(reg_en), 32'd0);
    clock();

    // 17 non-NOP instructions from reset wrap a 4-bit counter to 1
    sync_reset = 1'b1; clock();
    sync_reset = 1'b0; pm_data = 8'h27; clock();
    for (int i = 0; i < 17; i++) begin
      pm_data = (i % 2 == 0) ? 8'h27 : 8'hC5;
      clock();
    end
    settle();
    chk("wrap.retired", 32'(retired), 32'd1);

    for (int i = 0; i < 400; i++) begin
      sync_reset = ($urandom_range(0, 31) == 0);
      pm_data    = 8'($urandom);
      alu_zero   = 1'($urandom_range(0, 1));
      settle();
      check_all($sformatf("rnd%0d_%02h", i, pm_data));
      clock();
    end
    settle();
    check_state("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
